// File: rtl/otter_trap_ctrl.sv
// otter_trap_ctrl: trap/interrupt/mret sequencer driving the CSR file and fetch redirect; WFI sleep enabled by OTTER_TRAP_CTRL_WFI_EN
module otter_trap_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_vld,
  input  logic [31:0] pc,
  input  logic        is_ecall,
  input  logic        is_ebreak,
  input  logic        is_mret,
  input  logic        is_wfi,
  input  logic        is_csr,
  input  logic        csr_wr,
  input  logic        exc_vld,
  input  logic [2:0]  exc_cause,
  input  logic [31:0] exc_tval,
  input  logic        intrpt_vld,
  input  logic        wake,
  input  logic [31:0] mtvec,
  input  logic [31:0] mepc,
  output logic [2:0]  csr_op_sel,
  output logic [2:0]  csr_trap_cause_sel,
  output logic        csr_w_en,
  output logic [31:0] csr_pc_addr,
  output logic [31:0] csr_mtval,
  output logic        stall,
  output logic        redirect,
  output logic [31:0] redirect_pc
);
  localparam logic [2:0] CSR_OP_WRITE  = 3'd0;
  localparam logic [2:0] CSR_OP_RESET  = 3'd1;
  localparam logic [2:0] CSR_OP_TRAP   = 3'd2;
  localparam logic [2:0] CSR_OP_INTRPT = 3'd3;
  localparam logic [2:0] CSR_OP_ECALL  = 3'd4;
  localparam logic [2:0] CSR_OP_EBREAK = 3'd5;
  localparam logic [2:0] CSR_OP_MRET   = 3'd6;
  localparam logic [2:0] CSR_OP_WFI    = 3'd7;
  typedef enum logic [1:0] {INIT, RUN, REDIR, SLEEP} state_t;
  typedef enum logic [1:0] {T_MTVEC, T_MEPC, T_WFI} tgt_t;
  state_t      state;
  tgt_t        tgt;
  logic [31:0] wfi_pc;
  logic [2:0]  unused_in;
  assign unused_in = {wake, mtvec[1:0]};
  // the redirect target is picked up in REDIR so it reflects the CSR state after the trap/mret update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= INIT;
      tgt                <= T_MTVEC;
      wfi_pc             <= '0;
      csr_op_sel         <= CSR_OP_RESET;
      csr_trap_cause_sel <= '0;
      csr_w_en           <= 1'b0;
      csr_pc_addr        <= '0;
      csr_mtval          <= '0;
      stall              <= 1'b1;
      redirect           <= 1'b0;
      redirect_pc        <= '0;
    end else begin
      csr_op_sel         <= CSR_OP_WRITE;
      csr_trap_cause_sel <= '0;
      csr_w_en           <= 1'b0;
      csr_pc_addr        <= '0;
      csr_mtval          <= '0;
      stall              <= 1'b0;
      redirect           <= 1'b0;
      redirect_pc        <= '0;
      case (state)
        INIT: begin
          csr_op_sel  <= CSR_OP_RESET;
          stall       <= 1'b1;
          redirect    <= 1'b1;
          redirect_pc <= RESET_PC;
          state       <= RUN;
        end
        RUN: if (instr_vld) begin
          if (intrpt_vld) begin
            csr_op_sel  <= CSR_OP_INTRPT;
            csr_pc_addr <= pc;
            stall       <= 1'b1;
            tgt         <= T_MTVEC;
            state       <= REDIR;
          end else if (exc_vld) begin
            csr_op_sel         <= CSR_OP_TRAP;
            csr_trap_cause_sel <= exc_cause;
            csr_pc_addr        <= pc;
            csr_mtval          <= exc_tval;
            stall              <= 1'b1;
            tgt                <= T_MTVEC;
            state              <= REDIR;
          end else if (is_ecall) begin
            csr_op_sel  <= CSR_OP_ECALL;
            csr_pc_addr <= pc;
            stall       <= 1'b1;
            tgt         <= T_MTVEC;
            state       <= REDIR;
          end else if (is_ebreak) begin
            csr_op_sel  <= CSR_OP_EBREAK;
            csr_pc_addr <= pc;
            csr_mtval   <= pc;
            stall       <= 1'b1;
            tgt         <= T_MTVEC;
            state       <= REDIR;
          end else if (is_mret) begin
            csr_op_sel <= CSR_OP_MRET;
            stall      <= 1'b1;
            tgt        <= T_MEPC;
            state      <= REDIR;
          end else if (is_wfi) begin
`ifdef OTTER_TRAP_CTRL_WFI_EN
            csr_op_sel <= CSR_OP_WFI;
            stall      <= 1'b1;
            wfi_pc     <= pc + 32'd4;
            state      <= SLEEP;
`endif
          end else if (is_csr) begin
            csr_w_en <= csr_wr;
          end
        end
        REDIR: begin
          stall       <= 1'b1;
          redirect    <= 1'b1;
          redirect_pc <= tgt == T_MEPC ? mepc : tgt == T_WFI ? wfi_pc : {mtvec[31:2], 2'b00};
          state       <= RUN;
        end
        SLEEP: begin
`ifdef OTTER_TRAP_CTRL_WFI_EN
          stall <= 1'b1;
          if (wake) begin
            state <= REDIR;
            tgt   <= intrpt_vld ? T_MTVEC : T_WFI;
            if (intrpt_vld) begin
              csr_op_sel  <= CSR_OP_INTRPT;
              csr_pc_addr <= wfi_pc;
            end
          end
`else
          state <= RUN;
`endif
        end
      endcase
    end
  end
endmodule

// File: tb/tb_otter_trap_ctrl.sv
// tb_otter_trap_ctrl: directed and randomized checks of otter_trap_ctrl against a cycle-level behavioural model
module tb_otter_trap_ctrl;
  localparam logic [2:0] OP_WRITE = 3'd0, OP_RESET = 3'd1, OP_TRAP = 3'd2, OP_INTRPT = 3'd3;
  localparam logic [2:0] OP_ECALL = 3'd4, OP_EBREAK = 3'd5, OP_MRET = 3'd6, OP_WFI = 3'd7;
  logic clk = 1'b0, rst_n = 1'b0;
  logic instr_vld, is_ecall, is_ebreak, is_mret, is_wfi, is_csr, csr_wr, exc_vld, intrpt_vld, wake;
  logic [31:0] pc, exc_tval, mtvec, mepc;
  logic [2:0] exc_cause;
  logic [2:0] csr_op_sel, csr_trap_cause_sel;
  logic csr_w_en, stall, redirect;
  logic [31:0] csr_pc_addr, csr_mtval, redirect_pc;
  int checks = 0, failures = 0;
  bit m_init, m_sleep;
  int m_owed;
  logic [31:0] m_resume;

  otter_trap_ctrl dut (
    .clk(clk), .rst_n(rst_n), .instr_vld(instr_vld), .pc(pc),
    .is_ecall(is_ecall), .is_ebreak(is_ebreak), .is_mret(is_mret), .is_wfi(is_wfi), .is_csr(is_csr),
    .csr_wr(csr_wr), .exc_vld(exc_vld), .exc_cause(exc_cause), .exc_tval(exc_tval),
    .intrpt_vld(intrpt_vld), .wake(wake), .mtvec(mtvec), .mepc(mepc),
    .csr_op_sel(csr_op_sel), .csr_trap_cause_sel(csr_trap_cause_sel), .csr_w_en(csr_w_en),
    .csr_pc_addr(csr_pc_addr), .csr_mtval(csr_mtval), .stall(stall),
    .redirect(redirect), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    instr_vld = 0; is_ecall = 0; is_ebreak = 0; is_mret = 0; is_wfi = 0; is_csr = 0;
    csr_wr = 0; exc_vld = 0; exc_cause = 0; exc_tval = 0; intrpt_vld = 0; wake = 0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_op"}, {29'd0, csr_op_sel}, {29'd0, OP_RESET});
    chk({tag, "_stall"}, {31'd0, stall}, 32'd1);
    chk({tag, "_redirect"}, {31'd0, redirect}, 32'd0);
    chk({tag, "_rpc"}, redirect_pc, 32'd0);
    chk({tag, "_pca"}, csr_pc_addr, 32'd0);
    chk({tag, "_mtval"}, csr_mtval, 32'd0);
    chk({tag, "_cause_wen"}, {28'd0, csr_trap_cause_sel, csr_w_en}, 32'd0);
  endtask

  // asynchronous reset applied away from the clock edge, held two edges, then released
  task automatic do_reset();
    #2 rst_n = 0;
    #1 chk_reset_outputs("rst_async");
    repeat (2) @(posedge clk);
    #1 chk_reset_outputs("rst_hold");
    rst_n = 1;
    m_init = 1; m_sleep = 0; m_owed = 0; m_resume = 0;
  endtask

  // model: owed redirect kinds 1=trap vector, 2=mepc, 3=wfi resume
  task automatic step();
    logic [2:0] e_op, e_cause;
    logic e_wen, e_stall, e_red;
    logic [31:0] e_pca, e_mtval, e_rpc;
    @(posedge clk);
    e_op = OP_WRITE; e_cause = 0; e_wen = 0; e_pca = 0; e_mtval = 0; e_stall = 0; e_red = 0; e_rpc = 0;
    if (m_init) begin
      e_op = OP_RESET; e_stall = 1; e_red = 1; e_rpc = 32'h0; m_init = 0;
    end else if (m_owed != 0) begin
      e_stall = 1; e_red = 1;
      e_rpc = m_owed == 1 ? (mtvec & 32'hFFFF_FFFC) : m_owed == 2 ? mepc : m_resume;
      m_owed = 0;
    end else if (m_sleep) begin
      e_stall = 1;
      if (wake) begin
        m_sleep = 0;
        m_owed = intrpt_vld ? 1 : 3;
        if (intrpt_vld) begin e_op = OP_INTRPT; e_pca = m_resume; end
      end
    end else if (instr_vld) begin
      if (intrpt_vld) begin e_op = OP_INTRPT; e_pca = pc; e_stall = 1; m_owed = 1; end
      else if (exc_vld) begin e_op = OP_TRAP; e_cause = exc_cause; e_pca = pc; e_mtval = exc_tval; e_stall = 1; m_owed = 1; end
      else if (is_ecall) begin e_op = OP_ECALL; e_pca = pc; e_stall = 1; m_owed = 1; end
      else if (is_ebreak) begin e_op = OP_EBREAK; e_pca = pc; e_mtval = pc; e_stall = 1; m_owed = 1; end
      else if (is_mret) begin e_op = OP_MRET; e_stall = 1; m_owed = 2; end
      else if (is_wfi) begin
`ifdef OTTER_TRAP_CTRL_WFI_EN
        e_op = OP_WFI; e_stall = 1; m_sleep = 1; m_resume = pc + 32'd4;
`endif
      end else if (is_csr) e_wen = csr_wr;
    end
    #1;
    chk("op", {29'd0, csr_op_sel}, {29'd0, e_op});
    chk("cause", {29'd0, csr_trap_cause_sel}, {29'd0, e_cause});
    chk("w_en", {31'd0, csr_w_en}, {31'd0, e_wen});
    chk("pc_addr", csr_pc_addr, e_pca);
    chk("mtval", csr_mtval, e_mtval);
    chk("stall", {31'd0, stall}, {31'd0, e_stall});
    chk("redirect", {31'd0, redirect}, {31'd0, e_red});
    chk("redirect_pc", redirect_pc, e_rpc);
  endtask

  initial begin
    clr(); pc = 0; mtvec = 0; mepc = 0;
    @(posedge clk);
    do_reset();
    step(); chk("init_op", {29'd0, csr_op_sel}, {29'd0, OP_RESET}); chk("init_rpc", redirect_pc, 32'h0);
    step(); chk("run_stall", {31'd0, stall}, 32'd0);
    instr_vld = 1; pc = 32'h100; is_ecall = 1; mtvec = 32'h2001;
    step(); chk("ecall_op", {29'd0, csr_op_sel}, {29'd0, OP_ECALL}); chk("ecall_pca", csr_pc_addr, 32'h100);
    clr(); step(); chk("ecall_redir", {31'd0, redirect}, 32'd1); chk("ecall_rpc", redirect_pc, 32'h2000);
    step();
    instr_vld = 1; exc_vld = 1; is_ecall = 1; intrpt_vld = 1; exc_cause = 3'd5; exc_tval = 32'hDEAD;
    step(); chk("prio_op", {29'd0, csr_op_sel}, {29'd0, OP_INTRPT}); chk("prio_pca", csr_pc_addr, 32'h100);
    clr(); step(); step();
    instr_vld = 1; is_mret = 1; mepc = 32'h104;
    step(); chk("mret_op", {29'd0, csr_op_sel}, {29'd0, OP_MRET});
    clr(); step(); chk("mret_rpc", redirect_pc, 32'h104);
    step();
    instr_vld = 1; is_ecall = 1; pc = 32'h180; mtvec = 32'h3000;
    step(); clr(); mtvec = 32'h4002;
    step(); chk("late_mtvec_rpc", redirect_pc, 32'h4000);
    step();
    instr_vld = 1; is_wfi = 1; pc = 32'h200;
    step();
`ifdef OTTER_TRAP_CTRL_WFI_EN
    chk("wfi_op", {29'd0, csr_op_sel}, {29'd0, OP_WFI});
    clr();
    for (int i = 0; i < 5; i++) begin step(); chk("sleep_stall", {31'd0, stall}, 32'd1); end
    wake = 1; intrpt_vld = 1;
    step(); chk("wake_op", {29'd0, csr_op_sel}, {29'd0, OP_INTRPT}); chk("wake_pca", csr_pc_addr, 32'h204);
    clr(); step(); step();
    instr_vld = 1; is_wfi = 1; pc = 32'h300;
    step(); clr(); wake = 1;
    step(); clr(); step(); chk("wake_resume_rpc", redirect_pc, 32'h304);
    step();
`else
    chk("wfi_nostall", {31'd0, stall}, 32'd0); chk("wfi_idle", {29'd0, csr_op_sel}, {29'd0, OP_WRITE});
    clr(); step();
`endif
    instr_vld = 1; is_csr = 1; csr_wr = 1; is_wfi = 0;
    step(); chk("csr_wen", {31'd0, csr_w_en}, 32'd1); chk("csr_nostall", {31'd0, stall}, 32'd0);
    clr(); intrpt_vld = 1; is_ecall = 1;
    step(); chk("novld_idle", {31'd0, stall}, 32'd0);
    clr(); instr_vld = 1; is_ebreak = 1; pc = 32'h500;
    step(); clr(); step(); chk("redir_before_rst", {31'd0, redirect}, 32'd1);
    do_reset(); step(); step();
    for (int n = 0; n < 3000; n++) begin
      instr_vld = $urandom_range(0, 3) != 0;
      begin
        int sel = $urandom_range(0, 7);
        is_ecall = sel == 0; is_ebreak = sel == 1; is_mret = sel == 2; is_wfi = sel == 3; is_csr = sel == 4;
      end
      exc_vld = $urandom_range(0, 5) == 0; intrpt_vld = $urandom_range(0, 7) == 0;
      wake = $urandom_range(0, 3) == 0; csr_wr = 1'($urandom_range(0, 1));
      exc_cause = 3'($urandom_range(0, 7)); exc_tval = $urandom; pc = $urandom;
      mtvec = $urandom; mepc = $urandom;
      if ($urandom_range(0, 199) == 0) do_reset();
      step();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/otter_trap_ctrl.md
OTTER_TRAP_CTRL -- requirements
Module: otter_trap_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, named clk and rst_n.
REQ-002 The block SHALL have parameter RESET_PC, default 32'h0000_0000, the fetch address issued after reset initialisation.
REQ-003 The block SHALL have the following ports, in this order:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- instr_vld  in  1  an instruction is at the retire boundary this cycle
- pc  in  32  PC of that instruction
- is_ecall, is_ebreak, is_mret, is_wfi, is_csr  in  1 each  decoded instruction class
- csr_wr  in  1  the CSR instruction writes (rs1/uimm non-zero, or RW form)
- exc_vld  in  1  synchronous exception on this instruction
- exc_cause  in  3  TRAP_CAUSE_SEL_* code
- exc_tval  in  32  faulting address or instruction
- intrpt_vld  in  1  enabled interrupt pending (from the CSR file)
- wake  in  1  |(mie & mip), independent of mstatus.MIE
- mtvec, mepc  in  32 each  current CSR values
- csr_op_sel  out  3  CSR_OP_* command to the CSR file
- csr_trap_cause_sel  out  3  cause forwarded to the CSR file
- csr_w_en  out  1  CSR write enable
- csr_pc_addr  out  32  value to be latched into mepc
- csr_mtval  out  32  value to be latched into mtval
- stall  out  1  hold the pipeline front end
- redirect  out  1  one-cycle fetch redirect strobe
- redirect_pc  out  32  redirect target

Function
REQ-010 The FSM SHALL have the states INIT, RUN, REDIR and SLEEP.
REQ-011 Idle command SHALL be csr_op_sel=CSR_OP_WRITE with csr_w_en=0, i.e. a no-op.
REQ-012 INIT SHALL drive CSR_OP_RESET and stall=1 for exactly one cycle, with redirect=1 and redirect_pc=RESET_PC in that cycle, then go to RUN.
REQ-013 In RUN with instr_vld=1, the block SHALL select the action by fixed priority: intrpt_vld > exc_vld > is_ecall > is_ebreak > is_mret > is_wfi > is_csr.
REQ-014 Interrupt: the block SHALL drive CSR_OP_INTRPT and csr_pc_addr=pc; the instruction is not executed.
REQ-015 Exception: the block SHALL drive CSR_OP_TRAP, csr_trap_cause_sel=exc_cause, csr_pc_addr=pc and csr_mtval=exc_tval.
REQ-016 ecall and ebreak SHALL drive CSR_OP_ECALL and CSR_OP_EBREAK respectively, with csr_pc_addr=pc; for ebreak, csr_mtval=pc.
REQ-017 mret SHALL drive CSR_OP_MRET.
REQ-018 csr SHALL drive CSR_OP_WRITE with csr_w_en=csr_wr and SHALL stay in RUN without stall.
REQ-019 Every interrupt, exception, ecall, ebreak or mret SHALL assert stall in the issue cycle and go to REDIR.
REQ-020 REDIR SHALL assert stall=1 and redirect=1 for one cycle, then return to RUN.
REQ-021 The redirect target SHALL be sampled in REDIR, after the CSR update: {mtvec[31:2],2'b00} for traps and interrupts, mepc for mret.
REQ-022 When instr_vld=0, RUN SHALL issue the idle command, keep stall=0, and ignore all class inputs, including intrpt_vld.
REQ-023 All outputs SHALL be registered-state driven; csr_pc_addr and csr_mtval SHALL be 0 when not in use.
REQ-024 redirect_pc SHALL be 0 whenever redirect=0.

Reset
REQ-030 While rst_n=0, the block SHALL hold state=INIT, stall=1, redirect=0, redirect_pc=0, csr_op_sel=CSR_OP_RESET and all other outputs 0.
REQ-031 Reset asserted in any state, including mid-REDIR or SLEEP, SHALL abort immediately, with no redirect issued before INIT.

Configuration
REQ-040 With OTTER_TRAP_CTRL_WFI_EN defined:
- WFI SHALL drive CSR_OP_WFI, latch wfi_pc=pc+4 (mod 2^32) and enter SLEEP.
- SLEEP SHALL hold stall=1 and issue the idle command until wake=1.
- On wake with intrpt_vld=1, the block SHALL issue CSR_OP_INTRPT with csr_pc_addr=wfi_pc, then go to REDIR.
- On wake with intrpt_vld=0, the block SHALL go to REDIR with target wfi_pc.
REQ-041 With OTTER_TRAP_CTRL_WFI_EN undefined, WFI SHALL behave as the idle command with no stall, and SLEEP SHALL be unreachable.

Verification
REQ-050 Release rst_n -> one INIT cycle with CSR_OP_RESET and redirect_pc=0, then RUN with stall=0.
REQ-051 instr_vld=1, pc=0x100, is_ecall=1, mtvec=0x2001 -> CSR_OP_ECALL with csr_pc_addr=0x100, next cycle redirect=1 to 0x2000.
REQ-052 instr_vld=1, exc_vld=1, is_ecall=1 and intrpt_vld=1 together -> CSR_OP_INTRPT only, mepc value 0x100.
REQ-053 mret with mepc=0x104 -> CSR_OP_MRET, next cycle redirect_pc=0x104.
REQ-054 With WFI_EN: WFI at 0x200, wake raised after 5 cycles with intrpt_vld=1 -> stall held for 5 cycles, then CSR_OP_INTRPT with csr_pc_addr=0x204.
REQ-055 Assert rst_n=0 during REDIR -> redirect=0 immediately, then an INIT sequence.
